// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encodings, the log2 helper and the
// baud divisor macro used by both the transmit and receive paths.
`ifndef UART_PKG_SV
`define UART_PKG_SV

`define UART_BAUD(clk_hz, bit_rate) ((clk_hz) / (bit_rate))

package uart_pkg;

    localparam logic [1:0] TXW_IDLE  = 2'd0;
    localparam logic [1:0] TXW_START = 2'd1;
    localparam logic [1:0] TXW_DATA  = 2'd2;
    localparam logic [1:0] TXW_STOP  = 2'd3;

    // Ceiling log2 with a floor of 1, so a counter of this width always holds value-1.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

`endif

// File: rtl/uart_baud_gen.sv
// Loadable down-counter that marks the last cycle of each line symbol.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int width  = 4,
    parameter int reload = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic load,
    output logic tick
);

    logic [width-1:0] count;

    // Load wins over clear so the first symbol can start on the acceptance edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= width'(reload);
        end else if (clear) begin
            count <= '0;
        end else if (count != '0) begin
            count <= count - width'(1);
        end
    end

    assign tick = !clear && (count == '0);

endmodule

// File: rtl/uart_word_tx.sv
// 64-bit word transmitter: eight 8N1-style frames, least-significant byte first.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int baud_rate    = 9600,
    parameter int sys_clk_freq = 100000000,
    parameter int stop_bits    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] tx_word,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx,
    output logic        is_transmitting,
    output logic        byte_done,
    output logic        word_done
);

    localparam int         BAUD      = `UART_BAUD(sys_clk_freq, baud_rate);
    localparam int         CNT_W     = log2(BAUD);
    localparam logic [2:0] STOP_LAST = 3'(stop_bits - 1);

    logic [1:0]  state;
    logic [63:0] shreg;
    logic [2:0]  byte_cnt;
    logic [2:0]  bit_cnt;
    logic        busy;
    logic        accept;
    logic        tick;

    assign busy            = (state != TXW_IDLE);
    assign accept          = !busy && tx_valid;
    assign tx_ready        = !busy;
    assign is_transmitting = busy;

    uart_baud_gen #(
        .width (CNT_W),
        .reload(BAUD - 1)
    ) baud_gen (
        .clk  (clk),
        .rst  (rst),
        .clear(!busy),
        .load (accept || (busy && tick)),
        .tick (tick)
    );

    // bit_cnt counts data bits in DATA and completed stop bits in STOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= TXW_IDLE;
            shreg     <= '0;
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            tx        <= 1'b1;
            byte_done <= 1'b0;
            word_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            word_done <= 1'b0;
            case (state)
                TXW_IDLE: begin
                    tx <= 1'b1;
                    if (accept) begin
                        state    <= TXW_START;
                        shreg    <= tx_word;
                        byte_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= 1'b0;
                    end
                end
                TXW_START: begin
                    if (tick) begin
                        state   <= TXW_DATA;
                        bit_cnt <= '0;
                        tx      <= shreg[0];
                    end
                end
                TXW_DATA: begin
                    if (tick) begin
                        shreg <= {1'b0, shreg[63:1]};
                        if (bit_cnt == 3'd7) begin
                            state   <= TXW_STOP;
                            bit_cnt <= '0;
                            tx      <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shreg[1];
                        end
                    end
                end
                TXW_STOP: begin
                    if (tick) begin
                        if (bit_cnt == STOP_LAST) begin
                            byte_done <= 1'b1;
                            bit_cnt   <= '0;
                            if (byte_cnt == 3'd7) begin
                                word_done <= 1'b1;
                                state     <= TXW_IDLE;
                                tx        <= 1'b1;
                            end else begin
                                byte_cnt <= byte_cnt + 3'd1;
                                state    <= TXW_START;
                                tx       <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= TXW_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx with BAUD = 16 (one and two stop bits).
module tb_uart_word_tx;

    logic        clk;
    logic        rst;
    logic [63:0] tx_word;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx;
    logic        is_transmitting;
    logic        byte_done;
    logic        word_done;
    logic [63:0] b_word;
    logic        b_valid;
    logic        b_ready;
    logic        b_tx;
    logic        b_busy;
    logic        b_byte_done;
    logic        b_word_done;

    int n_cmp;
    int n_fail;

    logic tx_log   [0:1499];
    logic bd_log   [0:1499];
    logic wd_log   [0:1499];
    logic rdy_log  [0:1499];
    logic busy_log [0:1499];

    uart_word_tx #(.baud_rate(100), .sys_clk_freq(1600), .stop_bits(1)) dut (
        .clk(clk), .rst(rst), .tx_word(tx_word), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx(tx), .is_transmitting(is_transmitting),
        .byte_done(byte_done), .word_done(word_done)
    );

    uart_word_tx #(.baud_rate(100), .sys_clk_freq(1600), .stop_bits(2)) dut_b (
        .clk(clk), .rst(rst), .tx_word(b_word), .tx_valid(b_valid),
        .tx_ready(b_ready), .tx(b_tx), .is_transmitting(b_busy),
        .byte_done(b_byte_done), .word_done(b_word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level j cycles after the acceptance edge (16-cycle symbols).
    function automatic logic exp_tx(input logic [63:0] w, input int sb, input int j);
        int f;
        int k;
        int s;
        f = (9 + sb) * 16;
        if (j >= 8 * f) return 1'b1;
        k = j / f;
        s = (j % f) / 16;
        if (s == 0) return 1'b0;
        if (s <= 8) return w[8 * k + s - 1];
        return 1'b1;
    endfunction

    // Receiver model: sample each data bit mid-symbol and right-shift into a word.
    function automatic logic [63:0] decode(input int sb);
        logic [63:0] w;
        int f;
        f = (9 + sb) * 16;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 8; i++) begin
                w = {tx_log[k * f + 16 * (1 + i) + 8], w[63:1]};
            end
        end
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input bit use_b, input int n, input bit jitter);
        for (int j = 0; j < n; j++) begin
            if (use_b) begin
                tx_log[j] = b_tx; bd_log[j] = b_byte_done; wd_log[j] = b_word_done;
                rdy_log[j] = b_ready; busy_log[j] = b_busy;
            end else begin
                tx_log[j] = tx; bd_log[j] = byte_done; wd_log[j] = word_done;
                rdy_log[j] = tx_ready; busy_log[j] = is_transmitting;
            end
            if (jitter) begin
                if (j < 1280) begin
                    tx_valid = 1'($urandom_range(0, 1));
                    tx_word  = {$urandom, $urandom};
                end else begin
                    tx_valid = 1'b0;
                end
            end
            step();
        end
    endtask

    task automatic accept(input bit use_b, input logic [63:0] w);
        int waited;
        waited = 0;
        while ((use_b ? b_ready : tx_ready) !== 1'b1 && waited < 3000) begin
            step();
            waited++;
        end
        n_cmp++;
        if (waited >= 3000) begin
            n_fail++;
            $display("[TB] FAIL accept_wait: tx_ready got %b expected 1", use_b ? b_ready : tx_ready);
        end
        if (use_b) begin b_valid = 1'b1; b_word = w; end
        else begin tx_valid = 1'b1; tx_word = w; end
        step();
        b_valid  = 1'b0;
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp += 5;
        if (tx !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
        if (tx_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", tx_ready); end
        if (is_transmitting !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", is_transmitting); end
        if (byte_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_byte_done: got %b expected 0", byte_done); end
        if (word_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_word_done: got %b expected 0", word_done); end
        repeat (3) @(posedge clk);
        #4 rst = 1'b0;
        step();
        step();
        n_cmp++;
        if (tx !== 1'b1 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: tx/ready got %b%b expected 11", tx, tx_ready);
        end
    endtask

    task automatic test_single_word();
        int bad_tx, bad_bd, bad_wd, bad_rdy, bad_busy;
        logic [63:0] w;
        w = 64'h0123456789ABCDEF;
        accept(1'b0, w);
        capture(1'b0, 1290, 1'b0);
        bad_tx = 0; bad_bd = 0; bad_wd = 0; bad_rdy = 0; bad_busy = 0;
        for (int j = 0; j < 1290; j++) begin
            if (tx_log[j] !== exp_tx(w, 1, j)) bad_tx++;
            if (bd_log[j] !== (j > 0 && j % 160 == 0 && j <= 1280)) bad_bd++;
            if (wd_log[j] !== (j == 1280)) bad_wd++;
            if (rdy_log[j] !== (j >= 1280)) bad_rdy++;
            if (busy_log[j] !== (j < 1280)) bad_busy++;
        end
        n_cmp += 7;
        if (tx_log[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL start_latency: tx got %b expected 0", tx_log[0]); end
        if (bad_tx !== 0) begin n_fail++; $display("[TB] FAIL single_stream: %0d bad cycles expected 0", bad_tx); end
        if (decode(1) !== w) begin n_fail++; $display("[TB] FAIL single_decode: got %h expected %h", decode(1), w); end
        if (bad_bd !== 0) begin n_fail++; $display("[TB] FAIL single_byte_done: %0d bad cycles expected 0", bad_bd); end
        if (bad_wd !== 0) begin n_fail++; $display("[TB] FAIL single_word_done: %0d bad cycles expected 0", bad_wd); end
        if (bad_rdy !== 0) begin n_fail++; $display("[TB] FAIL single_ready: %0d bad cycles expected 0", bad_rdy); end
        if (bad_busy !== 0) begin n_fail++; $display("[TB] FAIL single_busy: %0d bad cycles expected 0", bad_busy); end
    endtask

    task automatic test_back_to_back();
        int bad;
        logic [63:0] w1, w2;
        w1 = 64'hFFFF_FFFF_0000_0000;
        w2 = 64'h5A5A_5A5A_5A5A_5A5A;
        while (tx_ready !== 1'b1) step();
        tx_valid = 1'b1;
        tx_word  = w1;
        step();
        tx_word = w2;
        capture(1'b0, 1281, 1'b0);
        tx_valid = 1'b0;
        bad = 0;
        for (int j = 0; j < 1281; j++) if (tx_log[j] !== exp_tx(w1, 1, j)) bad++;
        n_cmp += 4;
        if (bad !== 0) begin n_fail++; $display("[TB] FAIL b2b_stream1: %0d bad cycles expected 0", bad); end
        if (decode(1) !== w1) begin n_fail++; $display("[TB] FAIL b2b_decode1: got %h expected %h", decode(1), w1); end
        if (wd_log[1280] !== 1'b1 || rdy_log[1280] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL b2b_word_done1: done/ready got %b%b expected 11", wd_log[1280], rdy_log[1280]);
        end
        if (tx !== 1'b0 || tx_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_next_start: tx/ready got %b%b expected 00", tx, tx_ready);
        end
        capture(1'b0, 1290, 1'b0);
        bad = 0;
        for (int j = 0; j < 1290; j++) if (tx_log[j] !== exp_tx(w2, 1, j)) bad++;
        n_cmp += 2;
        if (bad !== 0) begin n_fail++; $display("[TB] FAIL b2b_stream2: %0d bad cycles expected 0", bad); end
        if (decode(1) !== w2) begin n_fail++; $display("[TB] FAIL b2b_decode2: got %h expected %h", decode(1), w2); end
    endtask

    task automatic test_busy_ignore();
        int bad_tx, bad_rdy;
        logic [63:0] w;
        w = 64'hA5C3_0F1E_7788_9911;
        accept(1'b0, w);
        capture(1'b0, 1290, 1'b1);
        bad_tx = 0;
        bad_rdy = 0;
        for (int j = 0; j < 1290; j++) begin
            if (tx_log[j] !== exp_tx(w, 1, j)) bad_tx++;
            if (rdy_log[j] !== (j >= 1280)) bad_rdy++;
        end
        n_cmp += 3;
        if (bad_tx !== 0) begin n_fail++; $display("[TB] FAIL busy_stream: %0d bad cycles expected 0", bad_tx); end
        if (decode(1) !== w) begin n_fail++; $display("[TB] FAIL busy_decode: got %h expected %h", decode(1), w); end
        if (bad_rdy !== 0) begin n_fail++; $display("[TB] FAIL busy_ready: %0d bad cycles expected 0", bad_rdy); end
    endtask

    task automatic test_async_reset();
        int bad;
        int pulses;
        accept(1'b0, 64'h0);
        repeat (3 * 160 + 16 * 3 + 5) step();
        n_cmp++;
        if (tx !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_frame_low: tx got %b expected 0", tx); end
        #3 rst = 1'b1;
        #1;
        n_cmp += 3;
        if (tx !== 1'b1) begin n_fail++; $display("[TB] FAIL async_tx: got %b expected 1", tx); end
        if (tx_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL async_ready: got %b expected 1", tx_ready); end
        if (is_transmitting !== 1'b0) begin n_fail++; $display("[TB] FAIL async_busy: got %b expected 0", is_transmitting); end
        @(posedge clk);
        #4 rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (word_done !== 1'b0 || byte_done !== 1'b0 || tx !== 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin n_fail++; $display("[TB] FAIL no_done_after_reset: %0d bad cycles expected 0", pulses); end
        accept(1'b0, 64'h1);
        capture(1'b0, 1290, 1'b0);
        bad = 0;
        for (int j = 0; j < 1290; j++) if (tx_log[j] !== exp_tx(64'h1, 1, j)) bad++;
        n_cmp += 2;
        if (bad !== 0) begin n_fail++; $display("[TB] FAIL restart_stream: %0d bad cycles expected 0", bad); end
        if (decode(1) !== 64'h1) begin n_fail++; $display("[TB] FAIL restart_decode: got %h expected %h", decode(1), 64'h1); end
    endtask

    task automatic test_two_stop_bits();
        int bad_tx, bad_bd, bad_wd;
        accept(1'b1, 64'h0);
        capture(1'b1, 1420, 1'b0);
        bad_tx = 0; bad_bd = 0; bad_wd = 0;
        for (int j = 0; j < 1420; j++) begin
            if (tx_log[j] !== exp_tx(64'h0, 2, j)) bad_tx++;
            if (bd_log[j] !== (j > 0 && j % 176 == 0 && j <= 1408)) bad_bd++;
            if (wd_log[j] !== (j == 1408)) bad_wd++;
        end
        n_cmp += 4;
        if (bad_tx !== 0) begin n_fail++; $display("[TB] FAIL stop2_stream: %0d bad cycles expected 0", bad_tx); end
        if (bad_bd !== 0) begin n_fail++; $display("[TB] FAIL stop2_byte_done: %0d bad cycles expected 0", bad_bd); end
        if (bad_wd !== 0) begin n_fail++; $display("[TB] FAIL stop2_word_done: %0d bad cycles expected 0", bad_wd); end
        if (rdy_log[1408] !== 1'b1 || busy_log[1407] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL stop2_ready: ready/busy got %b%b expected 11", rdy_log[1408], busy_log[1407]);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        tx_valid = 1'b0;
        tx_word  = '0;
        b_valid  = 1'b0;
        b_word   = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_busy_ignore();
        test_async_reset();
        test_two_stop_bits();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
